// File: rtl/spy_playback_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// spy_playback_sequencer_pkg
// Shared protocol definitions for the spy playback sequencer:
//   - playback mode encodings driven to the spy buffer
//   - host command opcodes
//   - sequencer FSM state encoding
//   - isPlayOp helper used when decoding commands
// ---------------------------------------------------------------------------
package spy_playback_sequencer_pkg;

    typedef enum logic [1:0] {
        NO_PLAYBACK    = 2'b00,
        PLAYBACK_ONCE  = 2'b01,
        PLAYBACK_LOOP  = 2'b10,
        PLAYBACK_WRITE = 2'b11
    } playbackMode_t;

    typedef enum logic [1:0] {
        CMD_STOP      = 2'b00,
        CMD_LOAD      = 2'b01,
        CMD_PLAY_ONCE = 2'b10,
        CMD_PLAY_LOOP = 2'b11
    } cmdOp_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_PLAY_ONCE = 3'd3,
        ST_PLAY_LOOP = 3'd4
    } seqState_t;

    function automatic logic isPlayOp(input cmdOp_t op);
        return (op == CMD_PLAY_ONCE) || (op == CMD_PLAY_LOOP);
    endfunction

endpackage

// File: rtl/spy_playback_sequencer_if.sv
// ---------------------------------------------------------------------------
// spy_playback_sequencer_if
// Host-side bus of the sequencer: command handshake plus load-word stream.
//   cmd_valid/cmd_ready   command handshake (host -> sequencer)
//   cmd_op                opcode (STOP/LOAD/PLAY_ONCE/PLAY_LOOP)
//   cmd_len               LOAD word count, 1..2**MEMWIDTH
//   load_valid/load_ready load-word handshake
//   load_data             load word, DATAWIDTH payload + metadata bit
// master = host, slave = sequencer.
// ---------------------------------------------------------------------------
interface spy_playback_sequencer_if #(
    parameter int DATAWIDTH = 64,
    parameter int MEMWIDTH  = 6
) ();

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [MEMWIDTH:0]    cmd_len;
    logic                 load_valid;
    logic                 load_ready;
    logic [DATAWIDTH:0]   load_data;

    modport master (
        output cmd_valid, cmd_op, cmd_len, load_valid, load_data,
        input  cmd_ready, load_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, load_valid, load_data,
        output cmd_ready, load_ready
    );

endinterface

// File: rtl/spy_playback_sequencer.sv
// ---------------------------------------------------------------------------
// spy_playback_sequencer
// Command-driven controller that loads a block of words into spy memory and
// then plays it back once or in a loop, counting words delivered to the FIFO.
// Ports:
//   clock, reset          sole clock, synchronous active-high reset
//   bus (slave)           command + load-word handshakes
//   playback_enable       one pulse per word the playback controller emits
//   playback              2-bit mode to the spy buffer
//   ram_write_enable_ext  spy memory write strobe
//   ram_write_data_ext    spy memory write word
//   busy                  high whenever not IDLE
//   done                  one-cycle pulse when LOAD or PLAY_ONCE completes
//   cmd_error             one-cycle pulse when a command is rejected
//   loop_count            completed PLAY_LOOP passes, saturating
// All outputs are registered except cmd_ready/load_ready (state decodes).
// ---------------------------------------------------------------------------
module spy_playback_sequencer
    import spy_playback_sequencer_pkg::*;
#(
    parameter int DATAWIDTH     = 64,
    parameter int MEMWIDTH      = 6,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    spy_playback_sequencer_if.slave bus,
    input  logic                    playback_enable,
    output logic [1:0]              playback,
    output logic                    ram_write_enable_ext,
    output logic [DATAWIDTH:0]      ram_write_data_ext,
    output logic                    busy,
    output logic                    done,
    output logic                    cmd_error,
    output logic [15:0]             loop_count
);

    localparam logic [MEMWIDTH:0] MAX_LEN     = {1'b1, {MEMWIDTH{1'b0}}};
    localparam logic [MEMWIDTH:0] ONE         = {{MEMWIDTH{1'b0}}, 1'b1};
    localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    seqState_t          r_state;
    seqState_t          w_nextState;
    logic               r_loaded;
    logic [MEMWIDTH:0]  r_lenReg;
    logic [MEMWIDTH:0]  r_wordCnt;
    logic [3:0]         r_settleCnt;
    logic               r_nextPlayLoop;
    logic [15:0]        r_loopCount;
    logic [1:0]         r_playback;
    logic               r_ramWe;
    logic [DATAWIDTH:0] r_ramWd;
    logic               r_busy;
    logic               r_done;
    logic               r_cmdError;

    cmdOp_t             w_op;
    logic               w_cmdReady;
    logic               w_cmdFire;
    logic               w_stop;
    logic               w_lenOk;
    logic               w_acceptLoad;
    logic               w_acceptPlay;
    logic               w_cmdReject;
    logic [MEMWIDTH:0]  w_wordCntInc;
    logic               w_lastWord;
    logic               w_loadBeat;
    logic               w_playBeat;
    logic               w_loadDone;
    logic               w_playDone;
    logic               w_loadedNext;
    logic [1:0]         w_playbackNext;

    // Commands are held off only while SETTLE forces the read address home,
    // so STOP can never interrupt that window.
    assign w_cmdReady     = (r_state != ST_SETTLE);
    assign bus.cmd_ready  = w_cmdReady;
    assign bus.load_ready = (r_state == ST_LOAD);

    assign w_op         = cmdOp_t'(bus.cmd_op);
    assign w_cmdFire    = bus.cmd_valid && w_cmdReady;
    assign w_stop       = w_cmdFire && (w_op == CMD_STOP);
    assign w_lenOk      = (bus.cmd_len != '0) && (bus.cmd_len <= MAX_LEN);
    assign w_acceptLoad = w_cmdFire && (r_state == ST_IDLE) && (w_op == CMD_LOAD) && w_lenOk;
    assign w_acceptPlay = w_cmdFire && (r_state == ST_IDLE) && isPlayOp(w_op) && r_loaded;
    // Anything that is neither STOP nor an accepted LOAD/PLAY is an error,
    // which also covers LOAD/PLAY arriving outside IDLE.
    assign w_cmdReject  = w_cmdFire && (w_op != CMD_STOP) && !w_acceptLoad && !w_acceptPlay;

    // STOP wins over a coincident load beat or playback pulse.
    assign w_wordCntInc = r_wordCnt + ONE;
    assign w_lastWord   = (w_wordCntInc == r_lenReg);
    assign w_loadBeat   = (r_state == ST_LOAD) && bus.load_valid && !w_stop;
    assign w_playBeat   = playback_enable && !w_stop &&
                          ((r_state == ST_PLAY_ONCE) || (r_state == ST_PLAY_LOOP));
    assign w_loadDone   = w_loadBeat && w_lastWord;
    assign w_playDone   = w_playBeat && (r_state == ST_PLAY_ONCE) && w_lastWord;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode; STOP returns to IDLE from any state that accepts it.
    always_comb begin
        w_nextState = r_state;
        if (w_stop) begin
            w_nextState = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acceptLoad) begin
                        w_nextState = ST_LOAD;
                    end else if (w_acceptPlay) begin
                        w_nextState = ST_SETTLE;
                    end
                end
                ST_LOAD: begin
                    if (w_loadDone) begin
                        w_nextState = ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_settleCnt == SETTLE_LAST) begin
                        w_nextState = r_nextPlayLoop ? ST_PLAY_LOOP : ST_PLAY_ONCE;
                    end
                end
                ST_PLAY_ONCE: begin
                    if (w_playDone) begin
                        w_nextState = ST_IDLE;
                    end
                end
                ST_PLAY_LOOP: begin
                    w_nextState = ST_PLAY_LOOP;
                end
                default: begin
                    w_nextState = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode: next values of the loaded flag and playback mode. IDLE
    // with data loaded keeps PLAYBACK_WRITE so spy-decision writes cannot
    // overwrite the loaded block.
    always_comb begin
        w_loadedNext = r_loaded;
        if (w_stop || w_acceptLoad) begin
            w_loadedNext = 1'b0;
        end else if (w_loadDone) begin
            w_loadedNext = 1'b1;
        end
        case (w_nextState)
            ST_IDLE:      w_playbackNext = w_loadedNext ? PLAYBACK_WRITE : NO_PLAYBACK;
            ST_PLAY_ONCE: w_playbackNext = PLAYBACK_ONCE;
            ST_PLAY_LOOP: w_playbackNext = PLAYBACK_LOOP;
            default:      w_playbackNext = PLAYBACK_WRITE;
        endcase
    end

    // Registered outputs, counters and command bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_loaded       <= 1'b0;
            r_lenReg       <= '0;
            r_wordCnt      <= '0;
            r_settleCnt    <= '0;
            r_nextPlayLoop <= 1'b0;
            r_loopCount    <= '0;
            r_playback     <= NO_PLAYBACK;
            r_ramWe        <= 1'b0;
            r_ramWd        <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_cmdError     <= 1'b0;
        end else begin
            r_loaded   <= w_loadedNext;
            r_playback <= w_playbackNext;
            r_busy     <= (w_nextState != ST_IDLE);
            r_done     <= w_loadDone || w_playDone;
            r_cmdError <= w_cmdReject;
            r_ramWe    <= w_loadBeat;
            if (w_loadBeat) begin
                r_ramWd <= bus.load_data;
            end
            if (w_acceptLoad) begin
                r_lenReg  <= bus.cmd_len;
                r_wordCnt <= '0;
            end else if (w_acceptPlay) begin
                r_wordCnt      <= '0;
                r_loopCount    <= '0;
                r_settleCnt    <= '0;
                r_nextPlayLoop <= (w_op == CMD_PLAY_LOOP);
            end else if (w_loadBeat) begin
                r_wordCnt <= w_wordCntInc;
            end else if (w_playBeat) begin
                if ((r_state == ST_PLAY_LOOP) && w_lastWord) begin
                    r_wordCnt <= '0;
                    if (r_loopCount != 16'hFFFF) begin
                        r_loopCount <= r_loopCount + 16'd1;
                    end
                end else begin
                    r_wordCnt <= w_wordCntInc;
                end
            end
            if (r_state == ST_SETTLE) begin
                r_settleCnt <= r_settleCnt + 4'd1;
            end
        end
    end

    assign playback             = r_playback;
    assign ram_write_enable_ext = r_ramWe;
    assign ram_write_data_ext   = r_ramWd;
    assign busy                 = r_busy;
    assign done                 = r_done;
    assign cmd_error            = r_cmdError;
    assign loop_count           = r_loopCount;

endmodule

// File: tb/tb_spy_playback_sequencer.sv
// ---------------------------------------------------------------------------
// tb_spy_playback_sequencer
// Directed bench for the spy playback sequencer. Stimulus pushes the
// expected write strobes, done pulses and error pulses into a queue; a
// negedge monitor pops and compares whenever the DUT presents one.
// ---------------------------------------------------------------------------
module tb_spy_playback_sequencer;
    import spy_playback_sequencer_pkg::*;

    localparam int DW = 64;
    localparam int MW = 6;
    localparam int EV_WRITE = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_ERR   = 2;

    typedef logic [DW:0] word_t;
    typedef struct {
        int    kind;
        word_t data;
    } expEvent_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        playback_enable = 1'b0;
    logic [1:0]  playback;
    logic        ram_write_enable_ext;
    word_t       ram_write_data_ext;
    logic        busy;
    logic        done;
    logic        cmd_error;
    logic [15:0] loop_count;

    expEvent_t expQ[$];
    int testsRun  = 0;
    int failCount = 0;

    always #5 clock = ~clock;

    spy_playback_sequencer_if #(.DATAWIDTH(DW), .MEMWIDTH(MW)) bus ();

    spy_playback_sequencer #(
        .DATAWIDTH(DW), .MEMWIDTH(MW), .SETTLE_CYCLES(2)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .bus                  (bus),
        .playback_enable      (playback_enable),
        .playback             (playback),
        .ram_write_enable_ext (ram_write_enable_ext),
        .ram_write_data_ext   (ram_write_data_ext),
        .busy                 (busy),
        .done                 (done),
        .cmd_error            (cmd_error),
        .loop_count           (loop_count)
    );

    function automatic string kindName(input int k);
        case (k)
            EV_WRITE: return "WRITE";
            EV_DONE:  return "DONE";
            default:  return "ERROR";
        endcase
    endfunction

    task automatic pushEvent(input int kind, input word_t data);
        expEvent_t e;
        e.kind = kind;
        e.data = data;
        expQ.push_back(e);
    endtask

    task automatic checkEvent(input int kind, input word_t data);
        expEvent_t e;
        testsRun++;
        if (expQ.size() == 0) begin
            failCount++;
            $display("[TB] FAIL event: got unexpected %s data=%h, required nothing", kindName(kind), data);
        end else begin
            e = expQ.pop_front();
            if (e.kind != kind || (kind == EV_WRITE && e.data != data)) begin
                failCount++;
                $display("[TB] FAIL event: got %s data=%h, required %s data=%h",
                         kindName(kind), data, kindName(e.kind), e.data);
            end
        end
    endtask

    task automatic checkOutput(input string name, input word_t actual, input word_t expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    // Monitor: write strobe, done and error pulses are the observable events.
    always @(negedge clock) begin
        if (ram_write_enable_ext) checkEvent(EV_WRITE, ram_write_data_ext);
        if (done)                 checkEvent(EV_DONE, '0);
        if (cmd_error)            checkEvent(EV_ERR, '0);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [MW:0] len);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = len;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic loadWords(input int n, input word_t base, input bit expectDone);
        for (int i = 0; i < n; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = base + word_t'(i);
            pushEvent(EV_WRITE, base + word_t'(i));
            if (expectDone && i == n - 1) pushEvent(EV_DONE, '0);
            tick();
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " playback"},   word_t'(playback), word_t'(0));
        checkOutput({tag, " ram_we"},     word_t'(ram_write_enable_ext), word_t'(0));
        checkOutput({tag, " ram_wd"},     ram_write_data_ext, word_t'(0));
        checkOutput({tag, " busy"},       word_t'(busy), word_t'(0));
        checkOutput({tag, " done"},       word_t'(done), word_t'(0));
        checkOutput({tag, " cmd_error"},  word_t'(cmd_error), word_t'(0));
        checkOutput({tag, " loop_count"}, word_t'(loop_count), word_t'(0));
        checkOutput({tag, " load_ready"}, word_t'(bus.load_ready), word_t'(0));
        checkOutput({tag, " cmd_ready"},  word_t'(bus.cmd_ready), word_t'(1));
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = CMD_STOP;
        bus.cmd_len    = '0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;

        // Reset state
        tick();
        tick();
        checkResetValues("reset");
        reset = 1'b0;
        tick();

        // Illegal commands in IDLE
        pushEvent(EV_ERR, '0);
        applyStimulus(CMD_LOAD, 7'd0);
        checkOutput("len0 busy", word_t'(busy), word_t'(0));
        pushEvent(EV_ERR, '0);
        applyStimulus(CMD_LOAD, 7'd65);
        checkOutput("len65 busy", word_t'(busy), word_t'(0));
        pushEvent(EV_ERR, '0);
        applyStimulus(CMD_PLAY_ONCE, 7'd0);
        checkOutput("play unloaded playback", word_t'(playback), word_t'(NO_PLAYBACK));

        // LOAD len=4, words 1..4 back-to-back
        applyStimulus(CMD_LOAD, 7'd4);
        checkOutput("load busy", word_t'(busy), word_t'(1));
        checkOutput("load playback", word_t'(playback), word_t'(PLAYBACK_WRITE));
        checkOutput("load load_ready", word_t'(bus.load_ready), word_t'(1));
        loadWords(4, word_t'(1), 1'b1);
        checkOutput("loaded playback", word_t'(playback), word_t'(PLAYBACK_WRITE));
        checkOutput("loaded busy", word_t'(busy), word_t'(0));
        checkOutput("loaded load_ready", word_t'(bus.load_ready), word_t'(0));
        tick();

        // PLAY_ONCE: two settle cycles, then four pulses complete the pass
        applyStimulus(CMD_PLAY_ONCE, 7'd0);
        checkOutput("settle1 playback", word_t'(playback), word_t'(PLAYBACK_WRITE));
        checkOutput("settle cmd_ready", word_t'(bus.cmd_ready), word_t'(0));
        tick();
        checkOutput("settle2 playback", word_t'(playback), word_t'(PLAYBACK_WRITE));
        tick();
        checkOutput("once playback", word_t'(playback), word_t'(PLAYBACK_ONCE));
        playback_enable = 1'b1;
        repeat (3) tick();
        pushEvent(EV_DONE, '0);
        tick();
        playback_enable = 1'b0;
        checkOutput("once end playback", word_t'(playback), word_t'(PLAYBACK_WRITE));
        checkOutput("once end busy", word_t'(busy), word_t'(0));
        tick();

        // PLAY_LOOP on a 3-word block, 10 pulses -> 3 complete passes
        applyStimulus(CMD_LOAD, 7'd3);
        loadWords(3, word_t'('hA), 1'b1);
        applyStimulus(CMD_PLAY_LOOP, 7'd0);
        tick();
        tick();
        checkOutput("loop playback", word_t'(playback), word_t'(PLAYBACK_LOOP));
        playback_enable = 1'b1;
        repeat (10) tick();
        playback_enable = 1'b0;
        checkOutput("loop_count", word_t'(loop_count), word_t'(3));
        pushEvent(EV_ERR, '0);
        applyStimulus(CMD_LOAD, 7'd4);
        checkOutput("load in loop playback", word_t'(playback), word_t'(PLAYBACK_LOOP));
        checkOutput("load in loop busy", word_t'(busy), word_t'(1));
        applyStimulus(CMD_STOP, 7'd0);
        checkOutput("stop loop playback", word_t'(playback), word_t'(NO_PLAYBACK));
        checkOutput("stop loop busy", word_t'(busy), word_t'(0));
        tick();

        // STOP coincident with the final load beat
        applyStimulus(CMD_LOAD, 7'd4);
        loadWords(3, word_t'('h40), 1'b0);
        bus.load_valid = 1'b1;
        bus.load_data  = word_t'('h43);
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = CMD_STOP;
        tick();
        bus.cmd_valid  = 1'b0;
        bus.load_valid = 1'b0;
        checkOutput("stop beat ram_we", word_t'(ram_write_enable_ext), word_t'(0));
        checkOutput("stop beat playback", word_t'(playback), word_t'(NO_PLAYBACK));
        checkOutput("stop beat load_ready", word_t'(bus.load_ready), word_t'(0));
        pushEvent(EV_ERR, '0);
        applyStimulus(CMD_PLAY_ONCE, 7'd0);
        checkOutput("stop beat unloaded busy", word_t'(busy), word_t'(0));

        // Reset in the middle of PLAY_ONCE
        applyStimulus(CMD_LOAD, 7'd2);
        loadWords(2, word_t'('h20), 1'b1);
        applyStimulus(CMD_PLAY_ONCE, 7'd0);
        tick();
        tick();
        playback_enable = 1'b1;
        tick();
        playback_enable = 1'b0;
        checkOutput("pre-reset busy", word_t'(busy), word_t'(1));
        reset = 1'b1;
        tick();
        checkResetValues("mid-play reset");
        reset = 1'b0;
        tick();
        tick();

        checkOutput("scoreboard drained", word_t'(expQ.size()), word_t'(0));
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
